// File: rtl/signal_capture_pkg.sv
// Shared constants and types for the signal capture writer.
//   ADDR_W / DATA_W / DEPTH : buffer geometry (8192 x 16)
//   cap_state_t             : capture FSM states
//   clamp_count()           : limits a requested sample count to the buffer depth
package signal_capture_pkg;

   localparam int unsigned ADDR_W = 13;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_TRIG = 2'd1,
      CAPTURE   = 2'd2,
      DONE      = 2'd3
   } cap_state_t;

   function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
      if (c > (ADDR_W + 1)'(DEPTH)) begin
         return (ADDR_W + 1)'(DEPTH);
      end
      return c;
   endfunction

endpackage

// File: rtl/signal_capture_trigger.sv
// Rising-edge level trigger.
//   clk, reset      : clock, async active-high reset
//   clear_i         : forget the previous sample (new capture armed)
//   active_i        : high while the FSM waits for the trigger
//   in_valid/in_data: sample stream
//   level_i         : signed threshold
//   trig_hit_o      : combinational, high in the cycle of the crossing sample
module signal_capture_trigger
   import signal_capture_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_i,
   input  logic              active_i,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0] level_i,
   output logic              trig_hit_o
);

   logic [DATA_W-1:0] prev_q;
   logic              prev_vld_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
      end else if (clear_i) begin
         prev_vld_q <= 1'b0;
      end else if (active_i && in_valid) begin
         prev_q     <= in_data;
         prev_vld_q <= 1'b1;
      end
   end

   // The first sample after arming only seeds prev_q and can never fire.
   assign trig_hit_o = active_i && in_valid && prev_vld_q
                       && ($signed(prev_q) < $signed(level_i))
                       && ($signed(in_data) >= $signed(level_i));

endmodule

// File: rtl/signal_capture_writer.sv
// Capture engine writing a configured number of (optionally decimated, optionally
// triggered) samples into port s2 of the signal buffer.
//   clk, reset                  : clock, async active-high reset
//   start, abort                : control pulses (abort wins)
//   cfg_*                       : capture configuration, latched on accepted start
//   in_valid, in_data           : unstallable sample stream
//   buf_*                       : s2 write port (one-cycle registered write pulses)
//   busy, done, triggered       : status
//   samples_written             : samples committed in the current capture
module signal_capture_writer
   import signal_capture_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W:0]   cfg_count,
   input  logic [7:0]        cfg_decim,
   input  logic              cfg_trig_en,
   input  logic [DATA_W-1:0] cfg_trig_level,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic [ADDR_W-1:0] buf_address,
   output logic              buf_chipselect,
   output logic              buf_write,
   output logic [DATA_W-1:0] buf_writedata,
   output logic [1:0]        buf_byteenable,
   output logic              busy,
   output logic              done,
   output logic              triggered,
   output logic [ADDR_W:0]   samples_written
);

   cap_state_t        state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   count_q;
   logic [7:0]        decim_q;
   logic [7:0]        dcnt_q;
   logic [DATA_W-1:0] level_q;
   logic [ADDR_W:0]   sw_q;
   logic              trig_q;
   logic              wr_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;

   logic              idle_like;
   logic              start_ok;
   logic              trig_hit;
   logic              accept;
   logic [ADDR_W:0]   count_clamped;
   logic [ADDR_W:0]   sw_inc;

   assign idle_like     = (state_q == IDLE) || (state_q == DONE);
   assign start_ok      = start && !abort && idle_like;
   assign count_clamped = clamp_count(cfg_count);
   assign sw_inc        = sw_q + (ADDR_W + 1)'(1);

   // A sample is committed on the trigger crossing itself or on decimation slot 0.
   assign accept = !abort
                   && (trig_hit || ((state_q == CAPTURE) && in_valid && (dcnt_q == 8'd0)));

   signal_capture_trigger u_trigger (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (start_ok),
      .active_i   (state_q == WAIT_TRIG),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .level_i    (level_q),
      .trig_hit_o (trig_hit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         count_q   <= '0;
         decim_q   <= '0;
         dcnt_q    <= '0;
         level_q   <= '0;
         sw_q      <= '0;
         trig_q    <= 1'b0;
         wr_q      <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_q <= 1'b0;
         if (abort) begin
            state_q <= IDLE;
         end else begin
            unique case (state_q)
               IDLE, DONE: begin
                  if (start) begin
                     addr_q  <= cfg_base;
                     count_q <= count_clamped;
                     decim_q <= cfg_decim;
                     level_q <= cfg_trig_level;
                     dcnt_q  <= 8'd0;
                     sw_q    <= '0;
                     trig_q  <= 1'b0;
                     if (count_clamped == '0) begin
                        state_q <= DONE;
                     end else if (cfg_trig_en) begin
                        state_q <= WAIT_TRIG;
                     end else begin
                        state_q <= CAPTURE;
                     end
                  end
               end
               WAIT_TRIG: begin
                  if (trig_hit) begin
                     trig_q  <= 1'b1;
                     state_q <= CAPTURE;
                     // The trigger sample occupies decimation slot 0.
                     dcnt_q  <= (decim_q == 8'd0) ? 8'd0 : 8'd1;
                  end
               end
               CAPTURE: begin
                  if (in_valid) begin
                     dcnt_q <= (dcnt_q == decim_q) ? 8'd0 : dcnt_q + 8'd1;
                  end
               end
               default: state_q <= IDLE;
            endcase

            // Overrides the state chosen above when this is the final sample.
            if (accept) begin
               wr_q      <= 1'b1;
               wr_addr_q <= addr_q;
               wr_data_q <= in_data;
               addr_q    <= addr_q + ADDR_W'(1);
               sw_q      <= sw_inc;
               if (sw_inc == count_q) begin
                  state_q <= DONE;
               end
            end
         end
      end
   end

   assign buf_address     = wr_addr_q;
   assign buf_chipselect  = wr_q;
   assign buf_write       = wr_q;
   assign buf_writedata   = wr_data_q;
   assign buf_byteenable  = 2'b11;
   assign busy            = (state_q == WAIT_TRIG) || (state_q == CAPTURE);
   assign done            = (state_q == DONE);
   assign triggered       = trig_q;
   assign samples_written = sw_q;

endmodule

// File: tb/tb_signal_capture_writer.sv
module tb_signal_capture_writer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [12:0] cfg_base = '0;
   logic [13:0] cfg_count = '0;
   logic [7:0]  cfg_decim = '0;
   logic        cfg_trig_en = 1'b0;
   logic [15:0] cfg_trig_level = '0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic [12:0] buf_address;
   logic        buf_chipselect;
   logic        buf_write;
   logic [15:0] buf_writedata;
   logic [1:0]  buf_byteenable;
   logic        busy;
   logic        done;
   logic        triggered;
   logic [13:0] samples_written;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [12:0] addr;
      logic [15:0] data;
   } wr_t;

   wr_t exp_q[$];

   signal_capture_writer dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .abort           (abort),
      .cfg_base        (cfg_base),
      .cfg_count       (cfg_count),
      .cfg_decim       (cfg_decim),
      .cfg_trig_en     (cfg_trig_en),
      .cfg_trig_level  (cfg_trig_level),
      .in_valid        (in_valid),
      .in_data         (in_data),
      .buf_address     (buf_address),
      .buf_chipselect  (buf_chipselect),
      .buf_write       (buf_write),
      .buf_writedata   (buf_writedata),
      .buf_byteenable  (buf_byteenable),
      .busy            (busy),
      .done            (done),
      .triggered       (triggered),
      .samples_written (samples_written)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int a, input int d);
      wr_t w;
      w.addr = 13'(a);
      w.data = 16'(d);
      exp_q.push_back(w);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int base, input int count, input int decim,
                           input logic ten, input int level);
      cfg_base       = 13'(base);
      cfg_count      = 14'(count);
      cfg_decim      = 8'(decim);
      cfg_trig_en    = ten;
      cfg_trig_level = 16'(level);
      start          = 1'b1;
      cyc();
      start          = 1'b0;
   endtask

   // Scoreboard: every write pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (buf_write) begin
         check_eq("cs_with_write", buf_chipselect, 1);
         if (exp_q.size() == 0) begin
            check_eq("unexpected_write_addr", buf_address, 32'hffff_ffff);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            check_eq("wr_addr", buf_address, w.addr);
            check_eq("wr_data", buf_writedata, w.data);
         end
      end
   end

   initial begin
      // Reset state
      cyc();
      cyc();
      check_eq("rst_write", buf_write, 0);
      check_eq("rst_cs", buf_chipselect, 0);
      check_eq("rst_addr", buf_address, 0);
      check_eq("rst_data", buf_writedata, 0);
      check_eq("rst_be", buf_byteenable, 2'b11);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_trig", triggered, 0);
      check_eq("rst_sw", samples_written, 0);
      reset = 1'b0;
      cyc();

      // Plain capture
      do_start(0, 4, 0, 1'b0, 0);
      check_eq("plain_busy", busy, 1);
      for (int i = 0; i < 4; i++) push_exp(i, i + 1);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 16'(i + 1);
         cyc();
         check_eq("plain_write", buf_write, 1);
         check_eq("plain_sw", samples_written, i + 1);
         check_eq("plain_done", done, (i == 3) ? 1 : 0);
      end
      in_valid = 1'b0;
      check_eq("plain_busy_end", busy, 0);
      cyc();
      check_eq("plain_q", exp_q.size(), 0);

      // Wrap-around
      do_start(8190, 3, 0, 1'b0, 0);
      push_exp(8190, 100);
      push_exp(8191, 101);
      push_exp(0, 102);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 16'(100 + i);
         cyc();
      end
      in_valid = 1'b0;
      cyc();
      check_eq("wrap_q", exp_q.size(), 0);
      check_eq("wrap_done", done, 1);

      // Clamp: 9000 requested, 8192 written, extra samples ignored
      do_start(5, 9000, 0, 1'b0, 0);
      for (int i = 0; i < 8192; i++) push_exp((5 + i) % 8192, i);
      for (int i = 0; i < 8200; i++) begin
         in_valid = 1'b1;
         in_data  = 16'(i);
         cyc();
      end
      in_valid = 1'b0;
      cyc();
      check_eq("clamp_q", exp_q.size(), 0);
      check_eq("clamp_sw", samples_written, 8192);
      check_eq("clamp_done", done, 1);

      // Decimation: keep 1 of 3
      do_start(100, 3, 2, 1'b0, 0);
      push_exp(100, 10);
      push_exp(101, 13);
      push_exp(102, 16);
      for (int i = 10; i <= 18; i++) begin
         in_valid = 1'b1;
         in_data  = 16'(i);
         cyc();
      end
      in_valid = 1'b0;
      cyc();
      check_eq("decim_q", exp_q.size(), 0);
      check_eq("decim_sw", samples_written, 3);

      // Trigger on rising crossing of 0
      do_start(50, 2, 0, 1'b1, 0);
      check_eq("trig_wait_busy", busy, 1);
      push_exp(50, 0);
      push_exp(51, 7);
      in_valid = 1'b1;
      in_data = 16'hfffb; cyc();
      in_data = 16'hffff; cyc();
      check_eq("trig_not_yet", triggered, 0);
      in_data = 16'h0000; cyc();
      check_eq("trig_set", triggered, 1);
      check_eq("trig_write0", buf_write, 1);
      in_data = 16'h0007; cyc();
      in_valid = 1'b0;
      check_eq("trig_done", done, 1);
      cyc();
      check_eq("trig_q", exp_q.size(), 0);

      // First sample cannot trigger (level 5, samples 5, 5)
      do_start(60, 2, 0, 1'b1, 5);
      in_valid = 1'b1;
      in_data = 16'd5; cyc();
      in_data = 16'd5; cyc();
      in_valid = 1'b0;
      check_eq("notrig_trig", triggered, 0);
      check_eq("notrig_busy", busy, 1);
      abort = 1'b1; cyc(); abort = 1'b0;
      check_eq("notrig_abort_busy", busy, 0);
      check_eq("notrig_abort_done", done, 0);

      // count = 0
      do_start(70, 0, 0, 1'b0, 0);
      check_eq("cnt0_done", done, 1);
      check_eq("cnt0_busy", busy, 0);
      check_eq("cnt0_sw", samples_written, 0);
      cyc();

      // start during CAPTURE is ignored
      do_start(200, 3, 0, 1'b0, 0);
      push_exp(200, 21);
      push_exp(201, 22);
      push_exp(202, 23);
      in_valid = 1'b1;
      in_data = 16'd21; cyc();
      cfg_base = 13'd0; cfg_count = 14'd1; start = 1'b1;
      in_data = 16'd22; cyc();
      start = 1'b0;
      in_data = 16'd23; cyc();
      in_valid = 1'b0;
      check_eq("restart_sw", samples_written, 3);
      check_eq("restart_done", done, 1);
      cyc();
      check_eq("restart_q", exp_q.size(), 0);

      // abort with in_valid high
      do_start(300, 5, 0, 1'b0, 0);
      push_exp(300, 1);
      in_valid = 1'b1;
      in_data = 16'd1; cyc();
      in_data = 16'd2; abort = 1'b1; cyc();
      abort = 1'b0; in_valid = 1'b0;
      check_eq("abort_write", buf_write, 0);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_done", done, 0);
      check_eq("abort_sw", samples_written, 1);
      cyc();
      check_eq("abort_q", exp_q.size(), 0);

      // Reset mid-capture
      do_start(400, 5, 0, 1'b1 ^ 1'b1, 0);
      push_exp(400, 31);
      push_exp(401, 32);
      in_valid = 1'b1;
      in_data = 16'd31; cyc();
      in_data = 16'd32; cyc();
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      check_eq("mrst_write", buf_write, 0);
      check_eq("mrst_addr", buf_address, 0);
      check_eq("mrst_data", buf_writedata, 0);
      check_eq("mrst_busy", busy, 0);
      check_eq("mrst_sw", samples_written, 0);
      cyc();
      reset = 1'b0;
      cyc();
      do_start(500, 2, 0, 1'b0, 0);
      push_exp(500, 41);
      push_exp(501, 42);
      in_valid = 1'b1;
      in_data = 16'd41; cyc();
      in_data = 16'd42; cyc();
      in_valid = 1'b0;
      check_eq("fresh_done", done, 1);
      check_eq("fresh_sw", samples_written, 2);
      cyc();
      check_eq("final_q", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
